// File: rtl/xy_mon_pkg.sv
// xy_mon_pkg: shared state encoding and pair-counter width for the x/y alternation monitor
package xy_mon_pkg;
  localparam int PAIRS_W = 8;
  typedef enum logic [1:0] {IDLE, EXP_Y, EXP_X} state_t;
endpackage

// File: rtl/xy_alt_seq_monitor_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear and async active-low reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc && !(&r_q)) r_q <= r_q + 1'b1;
  assign q = r_q;
endmodule

// File: rtl/xy_alt_seq_monitor.sv
// xy_alt_seq_monitor: FSM checker for the alternating x,y,x,y chain with saturating stats.
// Define XY_MON_SVA_EN to compile in embedded concurrent assertions.
module xy_alt_seq_monitor
  import xy_mon_pkg::*;
#(
  parameter int MAX_PAIRS = 2,
  parameter int CNT_W     = 8
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               x,
  input  logic               y,
  output logic               busy,
  output logic               match,
  output logic               fail,
  output logic [PAIRS_W-1:0] pairs,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);
  localparam logic [PAIRS_W-1:0] MAX_P = PAIRS_W'(MAX_PAIRS);
  state_t               r_state, w_state;
  logic [PAIRS_W-1:0]   r_pairs, w_pairs, w_pairs_inc;
  logic                 r_match, r_fail, r_busy, w_match, w_fail;
  assign w_pairs_inc = r_pairs + 1'b1;
  // clear beats everything; a dropped enable is a silent abort, not a failure
  always_comb begin
    w_state = r_state;
    w_pairs = r_pairs;
    w_match = 1'b0;
    w_fail  = 1'b0;
    if (clear) begin
      w_state = IDLE;
      w_pairs = '0;
    end else if (!enable) w_state = IDLE;
    else
      case (r_state)
        IDLE: if (x) begin
          w_state = EXP_Y;
          w_pairs = '0;
        end
        EXP_Y: if (y) begin
          w_pairs = w_pairs_inc;
          w_match = (w_pairs_inc == MAX_P);
          w_state = w_match ? IDLE : EXP_X;
        end else begin
          w_fail  = 1'b1;
          w_state = IDLE;
        end
        EXP_X: begin
          w_fail  = !x;
          w_state = x ? EXP_Y : IDLE;
        end
        default: w_state = IDLE;
      endcase
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pairs <= '0;
      r_match <= 1'b0;
      r_fail  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pairs <= w_pairs;
      r_match <= w_match;
      r_fail  <= w_fail;
      r_busy  <= (w_state != IDLE);
    end
  sat_counter #(.W(CNT_W)) u_match_cnt (
    .sysclk(sysclk), .rst_n(rst_n), .clr(clear), .inc(w_match), .q(match_cnt)
  );
  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .sysclk(sysclk), .rst_n(rst_n), .clr(clear), .inc(w_fail), .q(fail_cnt)
  );
  assign busy  = r_busy;
  assign match = r_match;
  assign fail  = r_fail;
  assign pairs = r_pairs;
`ifdef XY_MON_SVA_EN
  a_excl: assert property (@(posedge sysclk) disable iff (!rst_n) !(match && fail));
  a_match_y: assert property (@(posedge sysclk) disable iff (!rst_n) match |-> $past(y));
  a_fail_idle: assert property (@(posedge sysclk) disable iff (!rst_n) fail |-> !busy);
  a_pairs_max: assert property (@(posedge sysclk) disable iff (!rst_n) pairs <= MAX_P);
`else
`endif
endmodule

// File: tb/tb_xy_alt_seq_monitor.sv
// tb_xy_alt_seq_monitor: directed self-checking bench, MAX_PAIRS=2 and CNT_W=2
module tb_xy_alt_seq_monitor;
  logic       sysclk = 1'b0;
  logic       rst_n, enable, clear, x, y;
  logic       busy, match, fail;
  logic [7:0] pairs;
  logic [1:0] match_cnt, fail_cnt;
  int         n_chk = 0;
  int         n_err = 0;

  xy_alt_seq_monitor #(.MAX_PAIRS(2), .CNT_W(2)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .x(x), .y(y), .busy(busy), .match(match), .fail(fail),
    .pairs(pairs), .match_cnt(match_cnt), .fail_cnt(fail_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic xv, input logic yv);
    @(negedge sysclk);
    x = xv;
    y = yv;
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int b, input int m, input int f,
                         input int p, input int mc, input int fc);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".match"}, match, m);
    chk({tag, ".fail"}, fail, f);
    chk({tag, ".pairs"}, pairs, p);
    chk({tag, ".match_cnt"}, match_cnt, mc);
    chk({tag, ".fail_cnt"}, fail_cnt, fc);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; x = 1'b0; y = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge sysclk) rst_n = 1'b1;
    enable = 1'b1;
    // full chain x,y,x,y
    step(1, 0); chk_all("m1_x0", 1, 0, 0, 0, 0, 0);
    step(0, 1); chk_all("m1_y0", 1, 0, 0, 1, 0, 0);
    step(1, 0); chk_all("m1_x1", 1, 0, 0, 1, 0, 0);
    step(0, 1); chk_all("m1_y1", 0, 1, 0, 2, 1, 0);
    step(0, 0); chk_all("m1_after", 0, 0, 0, 2, 1, 0);
    // x,y,y breaks the chain
    step(1, 0); chk_all("f1_x", 1, 0, 0, 0, 1, 0);
    step(0, 1); chk_all("f1_y", 1, 0, 0, 1, 1, 0);
    step(0, 1); chk_all("f1_yy", 0, 0, 1, 1, 1, 1);
    step(0, 0); chk_all("f1_after", 0, 0, 0, 1, 1, 1);
    // both high: only the expected element counts
    step(1, 1); chk_all("bh_0", 1, 0, 0, 0, 1, 1);
    step(1, 1); chk_all("bh_1", 1, 0, 0, 1, 1, 1);
    step(1, 1); chk_all("bh_2", 1, 0, 0, 1, 1, 1);
    step(1, 1); chk_all("bh_3", 0, 1, 0, 2, 2, 1);
    // y alone in idle ignored
    step(0, 1); chk_all("idle_y", 0, 0, 0, 2, 2, 1);
    // enable drop in EXP_X aborts silently
    step(1, 0); step(0, 1); chk_all("ab_pre", 1, 0, 0, 1, 2, 1);
    enable = 1'b0;
    step(1, 0); chk_all("ab_drop", 0, 0, 0, 1, 2, 1);
    step(1, 0); chk_all("ab_nostart", 0, 0, 0, 1, 2, 1);
    enable = 1'b1;
    // fail counter saturates at 3
    step(1, 0); step(0, 0); chk_all("sat_f2", 0, 0, 1, 0, 2, 2);
    step(1, 0); step(0, 0); chk_all("sat_f3", 0, 0, 1, 0, 2, 3);
    step(1, 0); step(0, 0); chk_all("sat_f4", 0, 0, 1, 0, 2, 3);
    step(1, 0); step(0, 1); step(1, 0); step(0, 1); chk_all("sat_m3", 0, 1, 0, 2, 3, 3);
    step(1, 0); step(0, 1); step(1, 0); step(0, 1); chk_all("sat_m4", 0, 1, 0, 2, 3, 3);
    // clear on the final y suppresses the match
    step(1, 0); step(0, 1); step(1, 0);
    @(negedge sysclk) clear = 1'b1;
    step(0, 1); chk_all("clr", 0, 0, 0, 0, 0, 0);
    clear = 1'b0;
    step(0, 0); chk_all("clr_after", 0, 0, 0, 0, 0, 0);
    // async reset mid-chain
    step(1, 0); step(0, 0); chk_all("pre_rst_f", 0, 0, 1, 0, 0, 1);
    step(1, 0); step(0, 1); chk_all("pre_rst", 1, 0, 0, 1, 0, 1);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    x = 1'b1; y = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge sysclk);
    #1 chk_all("rst_start", 1, 0, 0, 0, 0, 0);
    step(0, 1); step(1, 0); step(0, 1); chk_all("rst_match", 0, 1, 0, 2, 1, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
